// File: rtl/multiplicador_sm_if.sv
// Start/operand/result bundle for the multiplicador_sm shift-and-add multiplier.
// The master drives the start level and operands; the slave returns product, done flag and state.
interface multiplicador_sm_if;
    logic        ini_mul;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [15:0] product;
    logic        mulEnd;
    logic [2:0]  state;

    modport master (output ini_mul, A, B, input product, mulEnd, state);
    modport slave  (input ini_mul, A, B, output product, mulEnd, state);
endinterface

// File: rtl/multiplicador_sm.sv
// Sequential 8x8 shift-and-add multiplier: 8 test/add/shift iterations, result held while ini_mul stays high.
// Define MULT_SIGNED_EN for two's-complement operands (magnitudes multiplied, sign applied on completion).
module multiplicador_sm (
    input  logic                   clk,
    input  logic                   rst,
    multiplicador_sm_if.slave      bus
);

    typedef enum logic [2:0] {
        INICIO  = 3'b000,
        TESTA   = 3'b001,
        SOMA    = 3'b010,
        DESLOCA = 3'b011,
        FIM     = 3'b101
    } state_t;

    state_t      r_state, w_state;
    logic [7:0]  r_m, w_m;
    logic [7:0]  r_p, w_p;
    logic [7:0]  r_q, w_q;
    logic        r_c, w_c;
    logic [2:0]  r_cont, w_cont;
    logic [15:0] r_product, w_product;
    logic        r_mul_end, w_mul_end;
    logic        r_neg, w_neg;
    logic [7:0]  w_load_m, w_load_q;
    logic        w_load_neg;
    logic [15:0] w_shifted;

`ifdef MULT_SIGNED_EN
    // |-128| wraps back to 8'h80, which the unsigned datapath reads as 128.
    assign w_load_m   = bus.A[7] ? (~bus.A + 8'd1) : bus.A;
    assign w_load_q   = bus.B[7] ? (~bus.B + 8'd1) : bus.B;
    assign w_load_neg = bus.A[7] ^ bus.B[7];
`else
    assign w_load_m   = bus.A;
    assign w_load_q   = bus.B;
    assign w_load_neg = 1'b0;
`endif

    assign w_shifted = {r_c, r_p, r_q[7:1]};

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state   = r_state;
        w_m       = r_m;
        w_p       = r_p;
        w_q       = r_q;
        w_c       = r_c;
        w_cont    = r_cont;
        w_neg     = r_neg;
        w_product = r_product;
        w_mul_end = 1'b0;

        case (r_state)
            INICIO: begin
                if (bus.ini_mul) begin
                    w_m     = w_load_m;
                    w_q     = w_load_q;
                    w_neg   = w_load_neg;
                    w_p     = 8'd0;
                    w_c     = 1'b0;
                    w_cont  = 3'd0;
                    w_state = TESTA;
                end
            end
            TESTA: begin
                if (!bus.ini_mul)  w_state = INICIO;
                else if (r_q[0])   w_state = SOMA;
                else               w_state = DESLOCA;
            end
            SOMA: begin
                if (!bus.ini_mul) begin
                    w_state = INICIO;
                end else begin
                    {w_c, w_p} = {1'b0, r_p} + {1'b0, r_m};
                    w_state    = DESLOCA;
                end
            end
            DESLOCA: begin
                if (!bus.ini_mul) begin
                    w_state = INICIO;
                end else begin
                    {w_c, w_p, w_q} = {1'b0, w_shifted};
                    w_cont          = r_cont + 3'd1;
                    if (r_cont == 3'd7) begin
                        w_state   = FIM;
                        w_mul_end = 1'b1;
`ifdef MULT_SIGNED_EN
                        w_product = r_neg ? (~w_shifted + 16'd1) : w_shifted;
`else
                        w_product = w_shifted;
`endif
                    end else begin
                        w_state = TESTA;
                    end
                end
            end
            FIM: begin
                if (bus.ini_mul) begin
                    w_mul_end = 1'b1;
                end else begin
                    w_state = INICIO;
                end
            end
            default: w_state = INICIO;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= INICIO;
            r_m       <= 8'd0;
            r_p       <= 8'd0;
            r_q       <= 8'd0;
            r_c       <= 1'b0;
            r_cont    <= 3'd0;
            r_neg     <= 1'b0;
            r_product <= 16'h0000;
            r_mul_end <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_m       <= w_m;
            r_p       <= w_p;
            r_q       <= w_q;
            r_c       <= w_c;
            r_cont    <= w_cont;
            r_neg     <= w_neg;
            r_product <= w_product;
            r_mul_end <= w_mul_end;
        end
    end

    assign bus.product = r_product;
    assign bus.mulEnd  = r_mul_end;
    assign bus.state   = r_state;

endmodule

// File: tb/tb_multiplicador_sm.sv
// Randomized bench for multiplicador_sm: products and latency compared with an arithmetic reference.
// Honours MULT_SIGNED_EN the same way the design does.
module tb_multiplicador_sm;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [15:0] last_product;

    multiplicador_sm_if bus ();

    multiplicador_sm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_product(input logic [7:0] a, input logic [7:0] b);
`ifdef MULT_SIGNED_EN
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        int pr = sa * sb;
        return pr[15:0];
`else
        int pr = int'(a) * int'(b);
        return pr[15:0];
`endif
    endfunction

    function automatic int ref_latency(input logic [7:0] b);
`ifdef MULT_SIGNED_EN
        int sb  = int'($signed(b));
        int mag = (sb < 0) ? -sb : sb;
        logic [7:0] m8 = mag[7:0];
        return 16 + $countones(m8);
`else
        return 16 + $countones(b);
`endif
    endfunction

    // Starts an operation from Inicio, scrambles A/B after the sampling edge,
    // then waits (bounded) for mulEnd and checks latency, product and state.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input string tag);
        logic [15:0] exp_p;
        int          exp_lat;
        int          cycles;
        bit          done;
        bit          held;
        exp_p   = ref_product(a, b);
        exp_lat = ref_latency(b);
        @(negedge clk);
        bus.A       = a;
        bus.B       = b;
        bus.ini_mul = 1'b1;
        @(posedge clk);
        #1;
        bus.A  = 8'($urandom);
        bus.B  = 8'($urandom);
        cycles = 0;
        done   = 1'b0;
        held   = 1'b1;
        while (!done && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
            if (bus.mulEnd) done = 1'b1;
            else if (bus.product !== last_product) held = 1'b0;
        end
        check({tag, " latency"}, 16'(cycles), 16'(exp_lat));
        check({tag, " product"}, bus.product, exp_p);
        check({tag, " state"}, 16'(bus.state), 16'h0005);
        check({tag, " product held while busy"}, 16'(held), 16'h0001);
        last_product = exp_p;
    endtask

    task automatic end_op(input string tag);
        @(negedge clk);
        bus.ini_mul = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " mulEnd low after drop"}, 16'(bus.mulEnd), 16'h0000);
        check({tag, " state idle after drop"}, 16'(bus.state), 16'h0000);
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        last_product = 16'h0000;
        rst          = 1'b1;
        bus.ini_mul  = 1'b0;
        bus.A        = 8'd0;
        bus.B        = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset product", bus.product, 16'h0000);
        check("reset mulEnd", 16'(bus.mulEnd), 16'h0000);
        check("reset state", 16'(bus.state), 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
`ifdef MULT_SIGNED_EN
        run_op(8'hFD, 8'h05, "neg3x5");
        end_op("neg3x5");
        run_op(8'h80, 8'h80, "m128xm128");
        end_op("m128xm128");
        run_op(8'h80, 8'h7F, "m128x127");
        end_op("m128x127");
`endif
        run_op(8'd13, 8'd11, "13x11");
        end_op("13x11");
        run_op(8'hFF, 8'hFF, "ffxff");
        end_op("ffxff");
        run_op(8'h5A, 8'h00, "5ax00");

        // Hold ini_mul high: no restart, product stable
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold mulEnd", 16'(bus.mulEnd), 16'h0001);
            check("hold product", bus.product, last_product);
        end
        end_op("5ax00");

        // Random operations
        for (int i = 0; i < 24; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (i == 3) rb = 8'hFF;
            if (i == 7) rb = 8'h00;
            if (i == 11) ra = 8'h80;
            run_op(ra, rb, "random");
            end_op("random");
        end

        // Abort: drop ini_mul before edge k+6
        @(negedge clk);
        bus.A       = 8'd200;
        bus.B       = 8'd3;
        bus.ini_mul = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk);
        bus.ini_mul = 1'b0;
        @(posedge clk);
        #1;
        check("abort state", 16'(bus.state), 16'h0000);
        check("abort mulEnd", 16'(bus.mulEnd), 16'h0000);
        check("abort product kept", bus.product, last_product);
        repeat (3) @(posedge clk);
        #1;
        check("abort stays idle", 16'(bus.mulEnd), 16'h0000);

        // Reset pulsed mid-cycle during an operation
        @(negedge clk);
        bus.ini_mul = 1'b1;
        @(posedge clk);
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async reset product", bus.product, 16'h0000);
        check("async reset mulEnd", 16'(bus.mulEnd), 16'h0000);
        check("async reset state", 16'(bus.state), 16'h0000);
        @(negedge clk);
        bus.ini_mul = 1'b0;
        rst         = 1'b0;
        last_product = 16'h0000;

        // Operation after reset works normally
        run_op(8'd7, 8'd9, "post reset");
        end_op("post reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
